// File: rtl/rr_arb8_dec_if.sv
// Request/grant bundle between the requesting units and the 8-way round-robin arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface rr_arb8_dec_if;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  tmo
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output tmo
  );
endinterface

// File: rtl/rr_arb8_dec.sv
// 8-way round-robin arbiter with a registered 3-bit winner index, one-hot decoded grant,
// hold timeout and a mandatory dead cycle between grants.
module rr_arb8_dec #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_arb8_dec_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic [7:0]    gnt_q, gnt_n;
  logic          vld_q, vld_n;
  logic          tmo_q, tmo_n;

  logic [2:0]    winner;
  logic          hold_done;
  logic          owner_req;

  // Rotating priority scan: the first set request at or after ptr wins.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign hold_done = (hold_cnt == CW'(MAX_HOLD - 1));
  assign owner_req = bus.req[idx];

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    idx_n      = idx;
    hold_cnt_n = hold_cnt;
    tmo_n      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req != 8'h00) begin
          idx_n      = winner;
          hold_cnt_n = '0;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        hold_cnt_n = hold_cnt + 1'b1;
        if (bus.rel || !owner_req || hold_done) begin
          state_n = GAP;
          ptr_n   = idx + 3'd1;
          // Timeout is only flagged when neither an explicit nor an implicit release beat it.
          tmo_n   = !bus.rel && owner_req && hold_done;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    vld_n = (state_n == BUSY);
    gnt_n = vld_n ? (8'h01 << idx_n) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      idx      <= 3'd0;
      hold_cnt <= '0;
      gnt_q    <= 8'h00;
      vld_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      hold_cnt <= hold_cnt_n;
      gnt_q    <= gnt_n;
      vld_q    <= vld_n;
      tmo_q    <= tmo_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx;
  assign bus.gnt_vld = vld_q;
  assign bus.tmo     = tmo_q;

endmodule
